// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite draw scheduler: FSM encoding,
// colour width/constants and a constant-evaluable clog2.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr
// (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               any
);

  logic [SEL_W-1:0] idx;
  int               pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    pos     = 0;
    // Walk from the farthest slot back to ptr so the nearest requester overwrites.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = SEL_W'(pos);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Request-driven sprite rasteriser: arbitrates requesters, scans the granted
// sprite through the shared ROM and plots offset, clipped pixels to the VGA adapter.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH_X      = 8,
  parameter int WIDTH_Y      = 7,
  parameter int RESOLUTION_X = 160,
  parameter int RESOLUTION_Y = 120,
  parameter int SPR_BITS     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WIDTH_X-1:0]  req_x,
  input  logic [NUM_REQ*WIDTH_Y-1:0]  req_y,
  input  logic [NUM_REQ*SPR_BITS-1:0] req_w,
  input  logic [NUM_REQ*SPR_BITS-1:0] req_h,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [clog2(NUM_REQ)-1:0]   rom_sel,
  output logic [SPR_BITS-1:0]         rom_x,
  output logic [SPR_BITS-1:0]         rom_y,
  input  logic [COLOR_W-1:0]          rom_color,
  output logic [WIDTH_X-1:0]          vga_x,
  output logic [WIDTH_Y-1:0]          vga_y,
  output logic [COLOR_W-1:0]          vga_color,
  output logic                        vga_plot
);

  localparam int SEL_W = clog2(NUM_REQ);
  localparam logic [WIDTH_X:0] CLIP_X = (WIDTH_X + 1)'(RESOLUTION_X);
  localparam logic [WIDTH_Y:0] CLIP_Y = (WIDTH_Y + 1)'(RESOLUTION_Y);

  state_t               state;
  logic [SEL_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_any;

  logic [WIDTH_X-1:0]   x_lat;
  logic [WIDTH_Y-1:0]   y_lat;
  logic [SPR_BITS-1:0]  w_lat;
  logic [SPR_BITS-1:0]  h_lat;

  logic [SPR_BITS-1:0]  lx_p0, ly_p0;
  logic                 vld_p0;
  logic [SPR_BITS-1:0]  lx_p1, ly_p1;
  logic                 vld_p1;
  logic [WIDTH_X:0]     sx_p1;
  logic [WIDTH_Y:0]     sy_p1;

  function automatic logic on_screen(input logic [WIDTH_X:0] sx, input logic [WIDTH_Y:0] sy);
    return (sx < CLIP_X) && (sy < CLIP_Y);
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      done    <= '0;
      rom_sel <= '0;
      lx_p0   <= '0;
      ly_p0   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant   <= arb_gnt;
            rom_sel <= arb_idx;
            lx_p0   <= '0;
            ly_p0   <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (lx_p0 == w_lat) begin
            lx_p0 <= '0;
            if (ly_p0 == h_lat) state <= DRAIN;
            else                ly_p0 <= ly_p0 + 1'b1;
          end else begin
            lx_p0 <= lx_p0 + 1'b1;
          end
        end
        DRAIN: state <= FINISH;
        FINISH: begin
          done  <= grant;
          grant <= '0;
          ptr   <= (rom_sel == SEL_W'(NUM_REQ - 1)) ? '0 : rom_sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Geometry is captured at grant so requesters may change it mid-service.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_any) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_gnt[i]) begin
          x_lat <= req_x[i*WIDTH_X +: WIDTH_X];
          y_lat <= req_y[i*WIDTH_Y +: WIDTH_Y];
          w_lat <= req_w[i*SPR_BITS +: SPR_BITS];
          h_lat <= req_h[i*SPR_BITS +: SPR_BITS];
        end
      end
    end
  end

  // p0: ROM address stage
  assign vld_p0 = (state == SCAN);
  assign rom_x  = lx_p0;
  assign rom_y  = ly_p0;

  // p1: ROM data stage
  always_ff @(posedge clk) begin
    lx_p1 <= lx_p0;
    ly_p1 <= ly_p0;
  end

  assign sx_p1 = {1'b0, x_lat} + {{(WIDTH_X + 1 - SPR_BITS){1'b0}}, lx_p1};
  assign sy_p1 = {1'b0, y_lat} + {{(WIDTH_Y + 1 - SPR_BITS){1'b0}}, ly_p1};

  // p2: registered plot outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= COLOR_BLACK;
    end else begin
      vld_p1   <= vld_p0;
      vga_plot <= vld_p1 && on_screen(sx_p1, sy_p1);
      if (vld_p1) begin
        vga_x     <= sx_p1[WIDTH_X-1:0];
        vga_y     <= sy_p1[WIDTH_Y-1:0];
        vga_color <= rom_color;
      end
    end
  end

endmodule
